// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the iterative cipher cores:
//   - FSM state encoding for the decryption core
//   - round count, round-constant table, byte/column index helpers
//   - forward and inverse S-box, computed as GF(2^8) inverse plus affine map
//   - forward and inverse single-step key schedule functions
// Byte order: [127:120] is byte 0; column c occupies [127-32c -: 32].
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KEYEXP = 2'd1,
        S_DEC    = 2'd2
    } fsm_t;

    localparam int unsigned NR = 10;

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input int unsigned c);
        return s[127-32*c -: 32];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int unsigned i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            r    = gf_mul(r, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // RotWord, SubWord and Rcon applied to the last word of a round key.
    function automatic logic [31:0] key_f(input logic [31:0] w, input logic [7:0] rc);
        return sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h0};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = get_col(k, 0) ^ key_f(get_col(k, 3), rc);
        n1 = get_col(k, 1) ^ n0;
        n2 = get_col(k, 2) ^ n1;
        n3 = get_col(k, 3) ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one expansion step: recover the previous round key from the next.
    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = get_col(k, 3) ^ get_col(k, 2);
        p2 = get_col(k, 2) ^ get_col(k, 1);
        p1 = get_col(k, 1) ^ get_col(k, 0);
        p0 = get_col(k, 0) ^ key_f(p3, rc);
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// Combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on last)
// Ports:
//   i_state [127:0]  state entering the round
//   i_rk    [127:0]  round key for this round
//   i_last           final round: bypass InvMixColumns
//   o_state [127:0]  state leaving the round
// -----------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] w_sub;
    logic [127:0] w_ark;
    logic [127:0] w_mix;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Row r is rotated right by r columns: output (r,c) takes input (r,c-r).
    always_comb begin
        w_sub = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                w_sub[127-8*(4*c+r) -: 8] = inv_sbox(get_byte(i_state, 4*((c+4-r)%4) + r));
            end
        end
    end

    assign w_ark = w_sub ^ i_rk;

    always_comb begin
        w_mix = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32] = inv_mix_col(get_col(w_ark, c));
        end
    end

    assign o_state = i_last ? w_ark : w_mix;

endmodule

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
// Iterative AES-128 decryption. The cipher key is first expanded forward to
// the round-10 key (10 clocks, the last one also applying AddRoundKey), then
// one inverse round runs per clock while the key schedule is walked backwards.
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   start               request, honoured only in IDLE
//   data_in   [127:0]   ciphertext, captured on accept
//   key_in    [127:0]   cipher key, captured on accept
//   busy                high while an operation is in flight
//   done                one-cycle pulse when data_out_dec is updated
//   data_out_dec[127:0] plaintext, held until the next completion
// -----------------------------------------------------------------------------
module aes_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out_dec
);

    fsm_t         r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;

    logic [127:0] w_fwd_key;
    logic [127:0] w_rk;
    logic [127:0] w_round;

    assign w_fwd_key = fwd_step(r_key, rcon(r_rnd));
    // During DEC r_key holds round key r+1; stepping back yields round key r.
    assign w_rk      = inv_step(r_key, rcon(r_rnd + 4'd1));

    aes_inv_round u_round (
        .i_state (r_state),
        .i_rk    (w_rk),
        .i_last  (r_rnd == 4'd0),
        .o_state (w_round)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= S_IDLE;
            r_state      <= '0;
            r_key        <= '0;
            r_rnd        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            data_out_dec <= '0;
        end else begin
            done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_state <= data_in;
                        r_key   <= key_in;
                        r_rnd   <= 4'd1;
                        busy    <= 1'b1;
                        r_fsm   <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    r_key <= w_fwd_key;
                    if (r_rnd == 4'(NR)) begin
                        r_state <= r_state ^ w_fwd_key;
                        r_rnd   <= 4'(NR - 1);
                        r_fsm   <= S_DEC;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                S_DEC: begin
                    r_key   <= w_rk;
                    r_state <= w_round;
                    if (r_rnd == 4'd0) begin
                        data_out_dec <= w_round;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        r_fsm        <= S_IDLE;
                    end else begin
                        r_rnd <= r_rnd - 4'd1;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_iter
// Directed vectors from FIPS-197 / SP800-38A, multi-cycle corner sequences,
// and a round trip against an independent behavioural AES-128 encryptor.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_iter;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [127:0] data_out_dec;

    int unsigned checks = 0;
    int unsigned errors = 0;

    aes_decrypt_iter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .data_in      (data_in),
        .key_in       (key_in),
        .busy         (busy),
        .done         (done),
        .data_out_dec (data_out_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---- independent encryption model (S-box built by generator iteration) ----
    logic [7:0] sb[256];

    function automatic logic [7:0] rl(input logic [7:0] v, input int k);
        return 8'((v << k) | (v >> (8 - k)));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] k[16];
        logic [7:0] tmp[4];
        logic [7:0] rc;
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tmp[0] = sb[k[13]] ^ rc;
            tmp[1] = sb[k[14]];
            tmp[2] = sb[k[15]];
            tmp[3] = sb[k[12]];
            for (int j = 0; j < 4; j++) k[j] = k[j] ^ tmp[j];
            for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
            rc = xt(rc);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c+rr] = sb[s[4*((c+rr)%4)+rr]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---- single operation from IDLE: latency and plaintext ----
    task automatic do_op(input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] exp_pt, input string name);
        int unsigned n;
        data_in = ct;
        key_in  = key;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = rnd128();
        key_in  = rnd128();
        check({name, " busy"}, 128'(busy), 128'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 128'(n), 128'd20);
        check({name, " pt"}, data_out_dec, exp_pt);
        check({name, " busy_end"}, 128'(busy), 128'd0);
    endtask

    task automatic watch_no_done(input int unsigned cycles, input string name);
        int unsigned seen;
        seen = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check(name, 128'(seen), 128'd0);
    endtask

    initial begin
        int unsigned n;
        int unsigned first;
        int unsigned ndone;
        int          seq[3];
        logic [127:0] k, p;

        rst = 1'b1; start = 1'b0; data_in = '0; key_in = '0;
        build_sbox();
        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt:  128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32,
                    pt:  128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    pt:  128'h6bc1bee22e409f96e93d7e117393172a};

        repeat (3) @(posedge clk); #1;
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        check("reset data_out", data_out_dec, 128'd0);
        rst = 1'b0;
        watch_no_done(10, "idle no done");

        // Directed vector table
        for (int i = 0; i < 3; i++) do_op(vecs[i].key, vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i));

        // Key schedule probe on App. B
        data_in = vecs[1].ct; key_in = vecs[1].key; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_in = rnd128(); key_in = rnd128();
        repeat (10) @(posedge clk);
        #1;
        check("probe rk10", dut.r_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("probe busy mid", 128'(busy), 128'd1);
        repeat (10) @(posedge clk);
        #1;
        check("probe rk0", dut.r_key, vecs[1].key);
        check("probe done", 128'(done), 128'd1);
        check("probe pt", data_out_dec, vecs[1].pt);

        // Start held high: B, C.1, B back to back, inputs changed mid-operation
        seq[0] = 1; seq[1] = 0; seq[2] = 1;
        data_in = vecs[seq[0]].ct; key_in = vecs[seq[0]].key; start = 1'b1;
        for (int b = 0; b < 3; b++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
                if (n == 5) begin data_in = rnd128(); key_in = rnd128(); end
            end while (!done && n < 60);
            check($sformatf("b2b%0d interval", b), 128'(n), 128'd21);
            check($sformatf("b2b%0d pt", b), data_out_dec, vecs[seq[b]].pt);
            if (b < 2) begin
                data_in = vecs[seq[b+1]].ct; key_in = vecs[seq[b+1]].key;
            end else begin
                start = 1'b0;
            end
        end
        watch_no_done(25, "b2b no extra done");

        // Reset at T7 of an operation
        data_in = vecs[0].ct; key_in = vecs[0].key; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst done", 128'(done), 128'd0);
        check("midrst data_out", data_out_dec, 128'd0);
        rst = 1'b0;
        watch_no_done(25, "midrst no done");
        do_op(vecs[0].key, vecs[0].ct, vecs[0].pt, "after_rst");

        // Start pulsed at T5 and T15 while busy
        data_in = vecs[2].ct; key_in = vecs[2].key; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first = 0; ndone = 0;
        for (int unsigned t = 1; t <= 45; t++) begin
            start = (t == 5 || t == 15);
            if (start) begin data_in = rnd128(); key_in = rnd128(); end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                if (ndone == 0) first = t;
                ndone++;
                if (ndone == 1) check("busystart pt", data_out_dec, vecs[2].pt);
            end
        end
        check("busystart first done", 128'(first), 128'd20);
        check("busystart done count", 128'(ndone), 128'd1);

        // Round trip through the behavioural encryptor
        for (int i = 0; i < 1000; i++) begin
            k = rnd128();
            p = rnd128();
            do_op(k, enc(k, p), p, $sformatf("rt%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative AES-128 decryption core: the inverse of the encryption datapath. It takes a 128-bit ciphertext and the original 128-bit cipher key, and derives the round-10 key by running the key schedule forward. It then applies the inverse cipher (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) one round per clock, walking the key schedule backwards on the fly, and returns the 128-bit plaintext. It sits beside the encryption core and shares its byte ordering and S-box conventions.

## Interface

Parameters:
- none; AES-128 only, 10 rounds fixed.

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- data_in  input  128  ciphertext, captured on the accepting edge
- key_in  input  128  cipher key (round-0 key), captured on the accepting edge
- busy  output  1  high from the accepting edge until the last round edge
- done  output  1  one-cycle pulse: data_out_dec valid
- data_out_dec  output  128  plaintext; held until the next accepted start

Byte order: bit [127:120] is byte 0 (FIPS-197 in0). Columns are 32-bit words, with [127:96] as column 0.

## Operation

- Registers:
  - state_q (128)
  - key_q (128)
  - rnd_q (4)
  - fsm: IDLE / KEYEXP / DEC
- IDLE, start=1 (edge T0):
  - state_q <= data_in, key_q <= key_in, rnd_q <= 1
  - busy <= 1, go KEYEXP
  - data_out_dec is not cleared.
- KEYEXP (edges T1..T10):
  - key_q <= fwd_step(key_q, rcon[rnd_q]), rnd_q++
  - fwd_step is the standard RotWord/SubWord/Rcon expansion.
  - On T10 (rnd_q=10): also state_q <= state_q ^ fwd_step(...), i.e. the initial AddRoundKey with rk10. Then rnd_q <= 9, go DEC.
- DEC (edges T11..T20, r = rnd_q from 9 down to 0):
  - rk_r = inv_step(key_q, rcon[r+1]), where w[i-4] = w[i] ^ f(w[i-1]) for the first word and w[i-4] = w[i] ^ w[i-1] for the others.
  - key_q <= rk_r.
  - t = InvSubBytes(InvShiftRows(state_q)) ^ rk_r.
  - state_q <= (r≠0) ? InvMixColumns(t) : t.
  - r=0 (T20): data_out_dec <= t, done <= 1, busy <= 0, go IDLE.
- start while busy: ignored; no queuing.
- start on the cycle done is high: accepted, because the FSM is already in IDLE.
- rst (any state, including mid-operation):
  - fsm=IDLE, busy=0, done=0, data_out_dec=0, state_q/key_q/rnd_q=0
  - In-flight operation is abandoned with no done.
- data_in/key_in may change freely after the accepting edge.

## Timing

- Reset values: busy=0, done=0, data_out_dec=128'h0.
- Latency: start accepted at edge T0 → done high in the cycle after edge T20 (20 clocks). The interval from done to the next possible done is 21 clocks.
- busy is high in the cycles following T0 through T19 and low after T20.
- done is a single-cycle pulse; data_out_dec is stable from done until the next accepted start's T20 edge.
- Throughput: one block per 21 cycles when start is held high continuously.
- Critical path: InvShiftRows → InvSubBytes → XOR → InvMixColumns, in parallel with inv_step (SubWord on one word).

## Structure

- Package aes_pkg holds:
  - the forward S-box and inverse S-box functions/tables
  - rcon table [1..10]
  - fsm state enum
  - the constants NR=10 and the byte/column index helpers
- Sub-module aes_inv_round, combinational:
  - inputs state, rk, last
  - output the next state
  - instantiates the inverse S-box ×16, InvShiftRows wiring and InvMixColumns (GF(2^8) xtime multiply by 9/11/13/14).
- Key forward/inverse steps are package functions; the top level holds only the FSM, registers and key stepping.

## Test plan

- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → done at T0+20, pt 00112233445566778899aabbccddeeff.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734. Probe key_q after T10 = d014f9a8c9ee2589e13f0cc8b6630ca6 and after T20 = key_in.
- Start held high for 3 blocks, with the App. B then App. C.1 then App. B vectors changing on each accept → exactly 3 done pulses 21 cycles apart, with the correct pt for each. Inputs toggled mid-operation have no effect.
- rst asserted at T7 of an operation → next cycle busy=0, done=0, data_out_dec=0. A following start completes normally with the correct pt.
- start pulsed at T5 and T15 while busy → ignored; a single done at T0+20.
- Round-trip: 1000 random key/pt pairs through the encryption core → decrypt → pt recovered. done never asserts without a prior accepted start.
